alarm_controller: RTL and testbench

Alarm stage that sits directly downstream of the time-of-day counter. It consumes the live 24-hour time (hours/minutes/seconds) and the per-second tick, stores a programmed alarm time, and runs the ring/snooze/stop state machine that drives the buzzer and status LEDs.

---
 rtl/alarm_controller.sv | 170 +++++++++++++++++
 tb/tb_alarm_controller.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
// Alarm stage behind the time-of-day counter: stores the alarm time and runs IDLE/ARMED/RINGING/SNOOZED.
// Optional ring timeout is built only when ALARM_TIMEOUT_EN is defined.
module alarm_controller #(
    parameter int SNOOZE_MINUTES = 5,
    parameter int MAX_SNOOZE     = 3,
    parameter int RING_SECONDS   = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [4:0] hours,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    input  logic       alarm_enable,
    input  logic       set_alarm,
    input  logic [4:0] set_hours,
    input  logic [5:0] set_minutes,
    input  logic       snooze,
    input  logic       stop,
    output logic       ringing,
    output logic       snoozing,
    output logic       armed,
    output logic [1:0] snooze_count,
    output logic [4:0] alarm_hours,
    output logic [5:0] alarm_minutes
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_RINGING = 2'd2;
    localparam logic [1:0] S_SNOOZED = 2'd3;

    if (SNOOZE_MINUTES < 1 || SNOOZE_MINUTES > 59 || MAX_SNOOZE < 0 || MAX_SNOOZE > 3
        || RING_SECONDS < 1) begin : g_param_check
        $error("alarm_controller: parameter out of range");
    end

    logic [1:0] state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [4:0] alarm_h_q, alarm_h_d;
    logic [5:0] alarm_m_q, alarm_m_d;
    logic [4:0] snz_h_q, snz_h_d;
    logic [5:0] snz_m_q, snz_m_d;
    logic       ringing_q, snoozing_q, armed_q;
    logic [6:0] snz_sum;
    logic       set_valid;
    logic       in_event;

`ifdef ALARM_TIMEOUT_EN
    localparam int TIMER_W = $clog2(RING_SECONDS + 1);
    logic [TIMER_W-1:0] timer_q, timer_d;
`endif

    assign snz_sum   = {1'b0, minutes} + 7'(SNOOZE_MINUTES);
    assign set_valid = set_alarm && (set_hours < 5'd24) && (set_minutes < 6'd60);
    assign in_event  = (state_q == S_RINGING) || (state_q == S_SNOOZED);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        alarm_h_d = alarm_h_q;
        alarm_m_d = alarm_m_q;
        snz_h_d   = snz_h_q;
        snz_m_d   = snz_m_q;
`ifdef ALARM_TIMEOUT_EN
        timer_d   = timer_q;
`endif
        if (!alarm_enable) begin
            state_d = S_IDLE;
            cnt_d   = 2'd0;
        end else begin
            if (state_q == S_IDLE) begin
                state_d = S_ARMED;
            end
            // Commands first; at most one of set/stop/snooze takes effect per cycle.
            if (set_valid) begin
                alarm_h_d = set_hours;
                alarm_m_d = set_minutes;
                if (in_event) begin
                    state_d = S_ARMED;
                    cnt_d   = 2'd0;
                end
            end else if (stop && in_event) begin
                state_d = S_ARMED;
                cnt_d   = 2'd0;
            end else if (snooze && (state_q == S_RINGING) && (cnt_q < 2'(MAX_SNOOZE))) begin
                state_d = S_SNOOZED;
                cnt_d   = cnt_q + 2'd1;
                if (snz_sum >= 7'd60) begin
                    snz_m_d = 6'(snz_sum - 7'd60);
                    snz_h_d = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
                end else begin
                    snz_m_d = snz_sum[5:0];
                    snz_h_d = hours;
                end
            end
            // Tick events act on the state left by the commands above.
            if (tick) begin
                case (state_d)
                    S_ARMED: begin
                        if (hours == alarm_h_d && minutes == alarm_m_d && seconds == 6'd0) begin
                            state_d = S_RINGING;
`ifdef ALARM_TIMEOUT_EN
                            timer_d = '0;
`endif
                        end
                    end
                    S_SNOOZED: begin
                        if (state_q == S_SNOOZED && hours == snz_h_q && minutes == snz_m_q
                            && seconds == 6'd0) begin
                            state_d = S_RINGING;
`ifdef ALARM_TIMEOUT_EN
                            timer_d = '0;
`endif
                        end
                    end
                    S_RINGING: begin
`ifdef ALARM_TIMEOUT_EN
                        if (timer_q == TIMER_W'(RING_SECONDS - 1)) begin
                            state_d = S_ARMED;
                            cnt_d   = 2'd0;
                        end else begin
                            timer_d = timer_q + 1'b1;
                        end
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 2'd0;
            alarm_h_q  <= 5'd0;
            alarm_m_q  <= 6'd0;
            snz_h_q    <= 5'd0;
            snz_m_q    <= 6'd0;
            ringing_q  <= 1'b0;
            snoozing_q <= 1'b0;
            armed_q    <= 1'b0;
`ifdef ALARM_TIMEOUT_EN
            timer_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            alarm_h_q  <= alarm_h_d;
            alarm_m_q  <= alarm_m_d;
            snz_h_q    <= snz_h_d;
            snz_m_q    <= snz_m_d;
            ringing_q  <= (state_d == S_RINGING);
            snoozing_q <= (state_d == S_SNOOZED);
            armed_q    <= (state_d != S_IDLE);
`ifdef ALARM_TIMEOUT_EN
            timer_q    <= timer_d;
`endif
        end
    end

    assign ringing       = ringing_q;
    assign snoozing      = snoozing_q;
    assign armed         = armed_q;
    assign snooze_count  = cnt_q;
    assign alarm_hours   = alarm_h_q;
    assign alarm_minutes = alarm_m_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Randomized and directed bench for alarm_controller against a time-of-day-in-seconds reference model.
module tb_alarm_controller;

    localparam int SNZ  = 5;
    localparam int MAXS = 3;
    localparam int RSEC = 60;

    logic       clk, reset, tick, alarm_enable, set_alarm, snooze, stop;
    logic [4:0] hours, set_hours, alarm_hours;
    logic [5:0] minutes, seconds, set_minutes, alarm_minutes;
    logic       ringing, snoozing, armed;
    logic [1:0] snooze_count;
    int         tod;

    int vectors = 0;
    int miscompares = 0;

    typedef enum int {M_IDLE, M_ARMED, M_RING, M_SNOOZE} mstate_t;
    mstate_t ms;
    int mcnt, malarm, mtarget, mtimer;

    alarm_controller #(.SNOOZE_MINUTES(SNZ), .MAX_SNOOZE(MAXS), .RING_SECONDS(RSEC)) dut (
        .clk(clk), .reset(reset), .tick(tick), .hours(hours), .minutes(minutes),
        .seconds(seconds), .alarm_enable(alarm_enable), .set_alarm(set_alarm),
        .set_hours(set_hours), .set_minutes(set_minutes), .snooze(snooze), .stop(stop),
        .ringing(ringing), .snoozing(snoozing), .armed(armed), .snooze_count(snooze_count),
        .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        hours   = 5'(tod / 3600);
        minutes = 6'((tod / 60) % 60);
        seconds = 6'(tod % 60);
    end

    wire [15:0] dut_vec = {ringing, snoozing, armed, snooze_count, alarm_hours, alarm_minutes};

    function automatic logic [15:0] exp_vec();
        return {ms == M_RING, ms == M_SNOOZE, ms != M_IDLE, 2'(mcnt), 5'(malarm / 60),
                6'(malarm % 60)};
    endfunction

    task automatic model_reset();
        ms = M_IDLE; mcnt = 0; malarm = 0; mtarget = 0; mtimer = 0;
    endtask

    // One clock of the reference: times as minutes-of-day, snooze target via modulo.
    task automatic model_clock();
        mstate_t prev = ms;
        int now_min = tod / 60;
        bit at_zero = (tod % 60) == 0;
        bit busy = (prev == M_RING) || (prev == M_SNOOZE);
        if (!alarm_enable) begin
            ms = M_IDLE; mcnt = 0;
            return;
        end
        if (prev == M_IDLE) ms = M_ARMED;
        if (set_alarm && set_hours < 24 && set_minutes < 60) begin
            malarm = int'(set_hours) * 60 + int'(set_minutes);
            if (busy) begin ms = M_ARMED; mcnt = 0; end
        end else if (stop && busy) begin
            ms = M_ARMED; mcnt = 0;
        end else if (snooze && prev == M_RING && mcnt < MAXS) begin
            ms = M_SNOOZE; mcnt++; mtarget = (now_min + SNZ) % 1440;
        end
        if (tick) begin
            if (ms == M_ARMED && now_min == malarm && at_zero) begin
                ms = M_RING; mtimer = 0;
            end else if (ms == M_SNOOZE && prev == M_SNOOZE && now_min == mtarget && at_zero) begin
                ms = M_RING; mtimer = 0;
            end else if (ms == M_RING && prev == M_RING) begin
`ifdef ALARM_TIMEOUT_EN
                mtimer++;
                if (mtimer == RSEC) begin ms = M_ARMED; mcnt = 0; end
`endif
            end
        end
    endtask

    task automatic step();
        model_clock();
        @(posedge clk);
        #1;
        tick = 0; set_alarm = 0; snooze = 0; stop = 0;
    endtask

    task automatic tick_at(input int t);
        tod = (t % 86400 + 86400) % 86400;
        tick = 1;
        step();
    endtask

    task automatic program_alarm(input int h, input int m);
        set_hours = 5'(h); set_minutes = 6'(m); set_alarm = 1;
        step();
    endtask

    task automatic go_armed();
        alarm_enable = 1; stop = 1;
        step();
        step();
    endtask

    task automatic ring_at(input int h, input int m);
        go_armed();
        program_alarm(h, m);
        tick_at(h * 3600 + m * 60 - 1);
        tick_at(h * 3600 + m * 60);
    endtask

    task automatic test_reset();
        reset = 0; alarm_enable = 0; tick = 0; set_alarm = 0; snooze = 0; stop = 0;
        set_hours = 0; set_minutes = 0; tod = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (dut_vec !== 16'h0) begin
            miscompares++; $display("FAIL reset_values got %h want %h", dut_vec, 16'h0);
        end
        reset = 1; alarm_enable = 1;
        step();
        vectors++;
        if (armed !== 1'b1 || dut_vec !== exp_vec()) begin
            miscompares++; $display("FAIL reset_arm got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_ring_once();
        go_armed();
        program_alarm(7, 30);
        vectors++;
        if (alarm_hours !== 5'd7 || alarm_minutes !== 6'd30) begin
            miscompares++; $display("FAIL load_alarm got %0d:%0d want 7:30", alarm_hours, alarm_minutes);
        end
        tick_at(7 * 3600 + 29 * 60 + 58);
        tick_at(7 * 3600 + 29 * 60 + 59);
        vectors++;
        if (ringing !== 1'b0) begin
            miscompares++; $display("FAIL early_ring got %b want 0", ringing);
        end
        tick_at(7 * 3600 + 30 * 60);
        vectors++;
        if (ringing !== 1'b1 || dut_vec !== exp_vec()) begin
            miscompares++; $display("FAIL ring_0730 got %h want %h", dut_vec, exp_vec());
        end
        stop = 1;
        step();
        for (int s = 1; s < 60; s++) begin
            tick_at(7 * 3600 + 30 * 60 + s);
            vectors++;
            if (ringing !== 1'b0 || dut_vec !== exp_vec()) begin
                miscompares++; $display("FAIL no_retrigger s=%0d got %h want %h", s, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_snooze_wrap();
        ring_at(23, 58);
        snooze = 1;
        step();
        vectors++;
        if (snoozing !== 1'b1 || snooze_count !== 2'd1 || ringing !== 1'b0) begin
            miscompares++; $display("FAIL snooze_enter got %b/%0d want 1/1", snoozing, snooze_count);
        end
        tick_at(2 * 60 + 59);
        vectors++;
        if (ringing !== 1'b0 || dut_vec !== exp_vec()) begin
            miscompares++; $display("FAIL snooze_early got %h want %h", dut_vec, exp_vec());
        end
        tick_at(3 * 60);
        vectors++;
        if (ringing !== 1'b1 || dut_vec !== exp_vec()) begin
            miscompares++; $display("FAIL snooze_wrap_ring got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_max_snooze();
        ring_at(12, 0);
        for (int k = 1; k <= MAXS; k++) begin
            snooze = 1;
            step();
            tick_at(12 * 3600 + k * SNZ * 60 - 1);
            tick_at(12 * 3600 + k * SNZ * 60);
            vectors++;
            if (ringing !== 1'b1 || snooze_count !== 2'(k)) begin
                miscompares++; $display("FAIL snooze_cycle k=%0d got %b/%0d want 1/%0d", k, ringing, snooze_count, k);
            end
        end
        snooze = 1;
        step();
        vectors++;
        if (ringing !== 1'b1 || snoozing !== 1'b0 || snooze_count !== 2'd3) begin
            miscompares++; $display("FAIL snooze_limit got %b/%0d want 1/3", ringing, snooze_count);
        end
        stop = 1;
        step();
        vectors++;
        if (armed !== 1'b1 || ringing !== 1'b0 || snooze_count !== 2'd0) begin
            miscompares++; $display("FAIL stop_after_limit got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_stop_snooze_same();
        ring_at(9, 15);
        stop = 1; snooze = 1;
        step();
        vectors++;
        if (armed !== 1'b1 || snoozing !== 1'b0 || ringing !== 1'b0) begin
            miscompares++; $display("FAIL stop_wins got %h want %h", dut_vec, exp_vec());
        end
        set_hours = 5'd24; set_minutes = 6'd10; set_alarm = 1;
        step();
        vectors++;
        if (alarm_hours !== 5'd9 || alarm_minutes !== 6'd15) begin
            miscompares++; $display("FAIL bad_set got %0d:%0d want 9:15", alarm_hours, alarm_minutes);
        end
    endtask

    task automatic test_timeout();
        int n;
        ring_at(6, 0);
`ifdef ALARM_TIMEOUT_EN
        n = RSEC;
`else
        n = 2 * RSEC;
`endif
        for (int s = 1; s <= n; s++) begin
            tick_at(6 * 3600 + s);
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++; $display("FAIL timeout_walk s=%0d got %h want %h", s, dut_vec, exp_vec());
            end
        end
        vectors++;
`ifdef ALARM_TIMEOUT_EN
        if (ringing !== 1'b0 || armed !== 1'b1) begin
            miscompares++; $display("FAIL timeout_end got %b/%b want 0/1", ringing, armed);
        end
`else
        if (ringing !== 1'b1) begin
            miscompares++; $display("FAIL no_timeout got %b want 1", ringing);
        end
`endif
    endtask

    task automatic test_async_reset();
        ring_at(18, 45);
        #2 reset = 0;
        #1;
        model_reset();
        vectors++;
        if (dut_vec !== 16'h0) begin
            miscompares++; $display("FAIL async_reset got %h want %h", dut_vec, 16'h0);
        end
        @(posedge clk);
        #1 reset = 1;
    endtask

    task automatic test_enable_low_snoozed();
        ring_at(10, 20);
        snooze = 1;
        step();
        alarm_enable = 0;
        step();
        vectors++;
        if (armed !== 1'b0 || snoozing !== 1'b0 || snooze_count !== 2'd0
            || alarm_hours !== 5'd10 || alarm_minutes !== 6'd20) begin
            miscompares++; $display("FAIL enable_low got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        go_armed();
        program_alarm(14, 2);
        for (int i = 0; i < 600; i++) begin
            int r = int'($urandom_range(0, 99));
            if (r < 4) tod = (malarm * 60 + 86400 - 1) % 86400;
            else if (r < 7) tod = (mtarget * 60 + 86400 - 1) % 86400;
            alarm_enable = ($urandom_range(0, 99) >= 2);
            tick = ($urandom_range(0, 2) != 0);
            if (tick) tod = (tod + 1) % 86400;
            set_alarm = ($urandom_range(0, 99) < 3);
            set_hours = 5'($urandom_range(0, 26));
            set_minutes = 6'($urandom_range(0, 62));
            snooze = ($urandom_range(0, 99) < 12);
            stop = ($urandom_range(0, 99) < 5);
            step();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++; $display("FAIL random i=%0d got %h want %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_ring_once();
        test_snooze_wrap();
        test_max_snooze();
        test_stop_snooze_same();
        test_timeout();
        test_async_reset();
        test_enable_low_snoozed();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
